// File: rtl/binary_to_bcd_six_digs_if.sv
// rtl/binary_to_bcd_six_digs_if.sv - start/busy/done handshake and BCD result bundle
// master is the requester; slave is the converter.
interface binary_to_bcd_six_digs_if #(
  parameter int BIN_WIDTH = 20
);
  logic                 start;
  logic [BIN_WIDTH-1:0] binIn;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [0:23]          bcdOut;

  modport master (
    output start, binIn,
    input  busy, done, overflow, bcdOut
  );

  modport slave (
    input  start, binIn,
    output busy, done, overflow, bcdOut
  );
endinterface

// File: rtl/binary_to_bcd_six_digs.sv
// rtl/binary_to_bcd_six_digs.sv - one-bit-per-clock double-dabble binary to six-digit BCD
// bcdOut digit i sits at bits [4i:4i+3], lowest index is the nibble MSB.
module binary_to_bcd_six_digs #(
  parameter int BIN_WIDTH = 20
) (
  input  logic                    clk,
  input  logic                    resetN,
  binary_to_bcd_six_digs_if.slave bus
);
  localparam int CW = 5;

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [23:0]          scratch_q, scratch_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_latch_q, ovf_latch_d;
  logic [0:23]          bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic [23:0]          adjusted;
  logic [31:0]          bin_ext;

  assign bin_ext = 32'(bus.binIn);

  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < 6; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    ovf_latch_d = ovf_latch_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d       = bus.binIn;
          scratch_d   = '0;
          cnt_d       = CW'(BIN_WIDTH);
          ovf_latch_d = (bin_ext > 32'd999999);
          state_d     = CONVERT;
        end
      end
      CONVERT: begin
        // Carry out of digit 5 drops; only reachable when the overflow latch is set.
        scratch_d = {adjusted[22:0], bin_q[BIN_WIDTH-1]};
        bin_d     = bin_q << 1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = FINISH;
      end
      FINISH: begin
        for (int i = 0; i < 6; i++)
          bcd_d[4*i +: 4] = ovf_latch_q ? 4'd9 : scratch_q[4*i +: 4];
        ovf_d   = ovf_latch_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_latch_q <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      ovf_latch_q <= ovf_latch_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.bcdOut   = bcd_q;
endmodule

// File: tb/tb_binary_to_bcd_six_digs.sv
// tb/tb_binary_to_bcd_six_digs.sv - directed self-checking bench for binary_to_bcd_six_digs
module tb_binary_to_bcd_six_digs;
  localparam int BW = 20;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  binary_to_bcd_six_digs_if #(.BIN_WIDTH(BW)) bus ();

  binary_to_bcd_six_digs #(.BIN_WIDTH(BW)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Decodes digit i from bits [4i:4i+3] of the packed word.
  function automatic int bcd_to_int(input logic [0:23] w);
    int v = 0;
    for (int i = 5; i >= 0; i--) v = v * 10 + int'(w[4*i +: 4]);
    return v;
  endfunction

  task automatic run_conv(input logic [BW-1:0] val, output logic [0:23] bcd,
                          output logic ovf, output int lat, output int busy_cnt,
                          output logic [0:23] mid_bcd);
    lat = -1; busy_cnt = 0; mid_bcd = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.binIn = val;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.binIn = '1;
      if (bus.busy) busy_cnt++;
      if (c == 10) mid_bcd = bus.bcdOut;
      if (bus.done) begin
        lat = c - 1;
        break;
      end
    end
    bcd = bus.bcdOut;
    ovf = bus.overflow;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.bcdOut !== 24'h000000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: bcd=%h busy=%b done=%b ovf=%b, required 000000 0 0 0",
               bus.bcdOut, bus.busy, bus.done, bus.overflow);
    end
  endtask

  task automatic test_zero();
    logic [0:23] b, m; logic o; int l, bc;
    run_conv('0, b, o, l, bc, m);
    n_cmp++;
    if (l !== 21) begin n_bad++; $display("FAIL zero_latency: got %0d, required 21", l); end
    n_cmp++;
    if (b !== 24'h000000) begin n_bad++; $display("FAIL zero_bcd: got %h, required 000000", b); end
  endtask

  task automatic test_basic();
    logic [0:23] b, m; logic o; int l, bc;
    run_conv(20'd123456, b, o, l, bc, m);
    n_cmp++;
    if (b !== 24'h654321) begin n_bad++; $display("FAIL basic_bcd: got %h, required 654321", b); end
    n_cmp++;
    if (o !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b, required 0", o); end
    n_cmp++;
    if (l !== 21) begin n_bad++; $display("FAIL basic_latency: got %0d, required 21", l); end
    n_cmp++;
    if (bc !== 21) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d, required 21", bc); end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b, required 0", bus.done); end
  endtask

  task automatic test_nines_overflow();
    logic [0:23] b, m; logic o; int l, bc;
    run_conv(20'd999999, b, o, l, bc, m);
    n_cmp++;
    if (b !== 24'h999999 || o !== 1'b0) begin
      n_bad++; $display("FAIL nines: got %h ovf=%b, required 999999 ovf=0", b, o);
    end
    run_conv(20'd1000000, b, o, l, bc, m);
    n_cmp++;
    if (b !== 24'h999999 || o !== 1'b1) begin
      n_bad++; $display("FAIL overflow: got %h ovf=%b, required 999999 ovf=1", b, o);
    end
    run_conv(20'd7, b, o, l, bc, m);
    n_cmp++;
    if (m !== 24'h999999) begin n_bad++; $display("FAIL hold_mid: got %h, required 999999", m); end
    n_cmp++;
    if (b !== 24'h700000 || o !== 1'b0) begin
      n_bad++; $display("FAIL after_overflow: got %h ovf=%b, required 700000 ovf=0", b, o);
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    logic [0:23] b = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.binIn = 20'd42;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus.start = (c == 5);
      bus.binIn = (c == 5) ? 20'd99 : 20'd42;
      if (bus.done) begin dones++; b = bus.bcdOut; end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (dones !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d, required 1", dones); end
    n_cmp++;
    if (b !== 24'h240000) begin n_bad++; $display("FAIL ignore_bcd: got %h, required 240000", b); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    logic [0:23] b, m; logic o; int l, bc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.binIn = 20'd555555;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    resetN = 1'b0;
    #1;
    n_cmp++;
    if (bus.bcdOut !== 24'h000000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: bcd=%h busy=%b done=%b ovf=%b, required 000000 0 0 0",
               bus.bcdOut, bus.busy, bus.done, bus.overflow);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    resetN = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL reset_mid_no_done: got %0d, required 0", dones); end
    run_conv(20'd555555, b, o, l, bc, m);
    n_cmp++;
    if (b !== 24'h555555 || l !== 21) begin
      n_bad++; $display("FAIL reset_mid_recover: got %h lat=%0d, required 555555 lat=21", b, l);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.binIn = 20'd31;
    for (int c = 1; c <= 80 && second < 0; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first < 0) first = c; else second = c;
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (second - first !== 22 || first < 0) begin
      n_bad++; $display("FAIL back_to_back_interval: got %0d, required 22", second - first);
    end
    n_cmp++;
    if (bus.bcdOut !== 24'h130000) begin
      n_bad++; $display("FAIL back_to_back_bcd: got %h, required 130000", bus.bcdOut);
    end
    repeat (25) @(negedge clk);
  endtask

  task automatic test_accum_values();
    logic [0:23] b1, b2, m; logic o; int l, bc;
    run_conv(20'd250, b1, o, l, bc, m);
    run_conv(20'd750, b2, o, l, bc, m);
    n_cmp++;
    if (b1 !== 24'h052000) begin n_bad++; $display("FAIL accum_250: got %h, required 052000", b1); end
    n_cmp++;
    if (b2 !== 24'h057000) begin n_bad++; $display("FAIL accum_750: got %h, required 057000", b2); end
    n_cmp++;
    if (bcd_to_int(b1) + bcd_to_int(b2) !== 1000) begin
      n_bad++; $display("FAIL accum_sum: got %0d, required 1000", bcd_to_int(b1) + bcd_to_int(b2));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.binIn = '0;
    repeat (3) @(negedge clk);
    test_reset();
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_zero();
    test_basic();
    test_nines_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_accum_values();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
